// File: rtl/mem_wb_if.sv
// MEM/WB pipeline bus: MEM-stage fields entering the W register and the
// registered W-stage fields plus register-file write enables leaving it.
// master drives the MEM-stage side, slave is the W pipeline register.
interface mem_wb_if #(
    parameter int DATA_W = 64
);
    logic [2:0]        m_stat;
    logic [3:0]        m_icode;
    logic [DATA_W-1:0] m_valE;
    logic [DATA_W-1:0] memwb_readdata;
    logic              m_mem_read;
    logic [3:0]        m_dstE;
    logic [3:0]        m_dstM;
    logic              m_dmem_error;

    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic              rf_we_E;
    logic              rf_we_M;

    modport master (
        output m_stat, m_icode, m_valE, memwb_readdata, m_mem_read,
               m_dstE, m_dstM, m_dmem_error,
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
               rf_we_E, rf_we_M
    );

    modport slave (
        input  m_stat, m_icode, m_valE, memwb_readdata, m_mem_read,
               m_dstE, m_dstM, m_dmem_error,
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
               rf_we_E, rf_we_M
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with halt tracking.
// Optional retired-instruction counter enabled by defining MEMWB_PERF_CNT_EN;
// without it the retired_count port and counter are not built.
//
// state  | meaning
// RUN    | W register follows stall/bubble/load controls
// HALTED | a non-AOK instruction has retired; W frozen until reset
module mem_wb_reg #(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwb_stall,
    input  logic         memwb_bubble,
    mem_wb_if.slave      bus,
    output logic         halted
`ifdef MEMWB_PERF_CNT_EN
    ,
    output logic [63:0]  retired_count
`endif
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [3:0] ICODE_NOP = 4'd1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [2:0]        W_stat_q,  W_stat_d;
    logic [3:0]        W_icode_q, W_icode_d;
    logic [DATA_W-1:0] W_valE_q,  W_valE_d;
    logic [DATA_W-1:0] W_valM_q,  W_valM_d;
    logic [3:0]        W_dstE_q,  W_dstE_d;
    logic [3:0]        W_dstM_q,  W_dstM_d;
    logic [2:0]        ld_stat;
    logic              load_en;

    // A load that fails its data access reports ADR even if MEM said AOK.
    assign ld_stat = (bus.m_mem_read && bus.m_dmem_error) ? STAT_ADR : bus.m_stat;

    // Next-state selection: HALTED hold > stall > bubble > load.
    always_comb begin
        state_d   = state_q;
        W_stat_d  = W_stat_q;
        W_icode_d = W_icode_q;
        W_valE_d  = W_valE_q;
        W_valM_d  = W_valM_q;
        W_dstE_d  = W_dstE_q;
        W_dstM_d  = W_dstM_q;
        load_en   = 1'b0;
        if (state_q == RUN && !memwb_stall) begin
            if (memwb_bubble) begin
                W_stat_d  = STAT_AOK;
                W_icode_d = ICODE_NOP;
                W_valE_d  = '0;
                W_valM_d  = '0;
                W_dstE_d  = RNONE;
                W_dstM_d  = RNONE;
            end else begin
                load_en   = 1'b1;
                W_stat_d  = ld_stat;
                W_icode_d = bus.m_icode;
                W_valE_d  = bus.m_valE;
                W_valM_d  = bus.m_mem_read ? bus.memwb_readdata : '0;
                W_dstE_d  = bus.m_dstE;
                W_dstM_d  = bus.m_dstM;
                if (ld_stat != STAT_AOK) begin
                    state_d = HALTED;
                end
            end
        end
    end

    // State and W registers; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            W_stat_q  <= STAT_AOK;
            W_icode_q <= ICODE_NOP;
            W_valE_q  <= '0;
            W_valM_q  <= '0;
            W_dstE_q  <= RNONE;
            W_dstM_q  <= RNONE;
        end else begin
            state_q   <= state_d;
            W_stat_q  <= W_stat_d;
            W_icode_q <= W_icode_d;
            W_valE_q  <= W_valE_d;
            W_valM_q  <= W_valM_d;
            W_dstE_q  <= W_dstE_d;
            W_dstM_q  <= W_dstM_d;
        end
    end

`ifdef MEMWB_PERF_CNT_EN
    logic [63:0] retired_count_q, retired_count_d;

    // Count AOK loads only, saturating at all-ones.
    always_comb begin
        retired_count_d = retired_count_q;
        if (load_en && ld_stat == STAT_AOK && retired_count_q != '1) begin
            retired_count_d = retired_count_q + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`endif

    assign bus.W_stat  = W_stat_q;
    assign bus.W_icode = W_icode_q;
    assign bus.W_valE  = W_valE_q;
    assign bus.W_valM  = W_valM_q;
    assign bus.W_dstE  = W_dstE_q;
    assign bus.W_dstM  = W_dstM_q;
    // Only a good instruction with a real destination may write back.
    assign bus.rf_we_E = (W_stat_q == STAT_AOK) && (W_dstE_q != RNONE);
    assign bus.rf_we_M = (W_stat_q == STAT_AOK) && (W_dstM_q != RNONE);
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: directed scenarios then random traffic,
// all checked against a behavioural model of the W register.
module tb_mem_wb_reg;

    logic clk = 1'b0;
    logic reset, stall, bubble, halted;
`ifdef MEMWB_PERF_CNT_EN
    logic [63:0] retired_count;
`endif

    always #5 clk = ~clk;

    mem_wb_if #(.DATA_W(64)) bus ();

    mem_wb_reg #(.DATA_W(64), .RNONE(4'hF)) dut (
        .clk          (clk),
        .reset        (reset),
        .memwb_stall  (stall),
        .memwb_bubble (bubble),
        .bus          (bus.slave),
        .halted       (halted)
`ifdef MEMWB_PERF_CNT_EN
        ,
        .retired_count(retired_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model of the architecturally visible W state
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_dstE, e_dstM;
    logic [63:0] e_valE, e_valM, e_cnt;
    logic        e_halted;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the update rules for one rising edge using the current inputs.
    task automatic model_edge();
        logic [2:0] s;
        if (reset) begin
            e_stat = 3'd1; e_icode = 4'd1; e_dstE = 4'hF; e_dstM = 4'hF;
            e_valE = 0; e_valM = 0; e_halted = 1'b0; e_cnt = 0;
        end else if (e_halted || stall) begin
            // hold
        end else if (bubble) begin
            e_stat = 3'd1; e_icode = 4'd1; e_dstE = 4'hF; e_dstM = 4'hF;
            e_valE = 0; e_valM = 0;
        end else begin
            s = (bus.m_mem_read && bus.m_dmem_error) ? 3'd3 : bus.m_stat;
            e_stat  = s;
            e_icode = bus.m_icode;
            e_valE  = bus.m_valE;
            e_valM  = bus.m_mem_read ? bus.memwb_readdata : 64'd0;
            e_dstE  = bus.m_dstE;
            e_dstM  = bus.m_dstM;
            if (s != 3'd1) e_halted = 1'b1;
            else if (e_cnt != 64'hFFFF_FFFF_FFFF_FFFF) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic check_all();
        chk("W_stat",  {61'd0, bus.W_stat},  {61'd0, e_stat});
        chk("W_icode", {60'd0, bus.W_icode}, {60'd0, e_icode});
        chk("W_valE",  bus.W_valE, e_valE);
        chk("W_valM",  bus.W_valM, e_valM);
        chk("W_dstE",  {60'd0, bus.W_dstE},  {60'd0, e_dstE});
        chk("W_dstM",  {60'd0, bus.W_dstM},  {60'd0, e_dstM});
        chk("rf_we_E", {63'd0, bus.rf_we_E}, {63'd0, (e_stat == 3'd1 && e_dstE != 4'hF)});
        chk("rf_we_M", {63'd0, bus.rf_we_M}, {63'd0, (e_stat == 3'd1 && e_dstM != 4'hF)});
        chk("halted",  {63'd0, halted},      {63'd0, e_halted});
`ifdef MEMWB_PERF_CNT_EN
        chk("retired_count", retired_count, e_cnt);
`endif
    endtask

    // One clock: model the edge, let the DUT take it, compare on the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_load(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                            input logic [63:0] rd, input logic rdn, input logic [3:0] de,
                            input logic [3:0] dm, input logic derr);
        bus.m_stat = st; bus.m_icode = ic; bus.m_valE = ve; bus.memwb_readdata = rd;
        bus.m_mem_read = rdn; bus.m_dstE = de; bus.m_dstM = dm; bus.m_dmem_error = derr;
    endtask

    task automatic rand_inputs();
        int r;
        r = $urandom_range(0, 19);
        bus.m_stat         = (r < 17) ? 3'd1 : 3'($urandom_range(2, 4));
        bus.m_icode        = 4'($urandom);
        bus.m_valE         = {$urandom, $urandom};
        bus.memwb_readdata = {$urandom, $urandom};
        bus.m_mem_read     = 1'($urandom);
        bus.m_dstE         = 4'($urandom);
        bus.m_dstM         = 4'($urandom);
        bus.m_dmem_error   = ($urandom_range(0, 15) == 0);
        stall              = ($urandom_range(0, 4) == 0);
        bubble             = ($urandom_range(0, 4) == 0);
        reset              = ($urandom_range(0, 24) == 0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; bubble = 1'b0;
        set_load(3'd1, 4'd0, 0, 0, 1'b0, 4'hF, 4'hF, 1'b0);
        @(negedge clk);
        cycle();
        reset = 1'b0;

        // load with memory read
        set_load(3'd1, 4'd5, 64'h1234, 64'hDEAD_BEEF, 1'b1, 4'hF, 4'd3, 1'b0);
        cycle();
        chk("ld_valM", bus.W_valM, 64'hDEAD_BEEF);
        chk("ld_weM", {63'd0, bus.rf_we_M}, 64'd1);
        chk("ld_weE", {63'd0, bus.rf_we_E}, 64'd0);

        // non-load: valM forced to zero
        set_load(3'd1, 4'd6, 64'h77, 64'hAAAA, 1'b0, 4'd2, 4'hF, 1'b0);
        cycle();

        // stall and bubble together hold; bubble alone inserts a NOP
        set_load(3'd1, 4'd2, 64'h55, 64'h66, 1'b1, 4'd7, 4'd8, 1'b0);
        stall = 1'b1; bubble = 1'b1;
        cycle();
        chk("stall_hold_icode", {60'd0, bus.W_icode}, 64'd6);
        stall = 1'b0;
        cycle();
        chk("bubble_dstE", {60'd0, bus.W_dstE}, 64'hF);
        chk("bubble_we", {62'd0, bus.rf_we_E, bus.rf_we_M}, 64'd0);
        bubble = 1'b0;

        // dmem error on an AOK load becomes ADR and halts
        set_load(3'd1, 4'd5, 64'h10, 64'h20, 1'b1, 4'hF, 4'd5, 1'b1);
        cycle();
        chk("adr_stat", {61'd0, bus.W_stat}, 64'd3);
        set_load(3'd1, 4'd3, 64'h99, 64'h98, 1'b0, 4'd1, 4'd2, 1'b0);
        cycle();
        bubble = 1'b1;
        cycle();
        bubble = 1'b0;

        // reset wins while halted, then HLT halts again
        reset = 1'b1; stall = 1'b1;
        cycle();
        reset = 1'b0; stall = 1'b0;
        set_load(3'd2, 4'd0, 0, 0, 1'b0, 4'hF, 4'hF, 1'b0);
        cycle();
        chk("hlt_halted", {63'd0, halted}, 64'd1);
        reset = 1'b1;
        cycle();
        chk("rst_icode", {60'd0, bus.W_icode}, 64'd1);
        reset = 1'b0;

`ifdef MEMWB_PERF_CNT_EN
        // 5 AOK loads, 2 bubbles, 3 stalls -> 5 retired
        for (int i = 0; i < 10; i++) begin
            set_load(3'd1, 4'(i), 64'(i), 0, 1'b0, 4'd1, 4'hF, 1'b0);
            stall  = (i >= 7);
            bubble = (i == 5 || i == 6);
            cycle();
        end
        stall = 1'b0; bubble = 1'b0;
        chk("cnt_five", retired_count, 64'd5);
        // saturation from a preset counter
        force dut.retired_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retired_count_q;
        e_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        chk("cnt_sat", retired_count, 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001: Parameter DATA_W, default 64, width of valE/valM datapath.
REQ-002: Parameter RNONE, default 4'hF, register ID meaning "no destination".
REQ-003: clk  in  1  single clock; all state updates on rising edge.
REQ-004: reset  in  1  synchronous, active-high reset.
REQ-005: memwb_stall  in  1  hold all W registers.
REQ-006: memwb_bubble  in  1  load a NOP into W.
REQ-007: m_stat  in  3  MEM-stage status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-008: m_icode  in  4  MEM-stage instruction code.
REQ-009: m_valE  in  DATA_W  ALU result.
REQ-010: memwb_readdata  in  DATA_W  load data from data memory, valid at the rising edge following the MEM cycle's falling edge.
REQ-011: m_mem_read  in  1  MEM-stage instruction is a load.
REQ-012: m_dstE / m_dstM  in  4 each  destination register IDs.
REQ-013: m_dmem_error  in  1  data address out of range (address[63:8] nonzero).
REQ-014: W_stat  out  3; W_icode  out  4; W_valE / W_valM  out  DATA_W; W_dstE / W_dstM  out  4.
REQ-015: rf_we_E / rf_we_M  out  1  register-file write enables.
REQ-016: halted  out  1  pipeline has retired a non-AOK instruction.
REQ-017: retired_count  out  64  retired-instruction counter (present only with the macro).

Function
REQ-018: Update priority per edge SHALL be: reset > HALTED hold > stall > bubble > load.
REQ-019: Load SHALL capture all m_* fields into W_* with a latency of one cycle.
REQ-020: On load, W_valM SHALL be memwb_readdata if m_mem_read=1, else 0.
REQ-021: On load, W_stat SHALL be 3 (ADR) when m_mem_read=1 and m_dmem_error=1 (also when m_stat=AOK); otherwise m_stat.
REQ-022: Bubble SHALL load: W_icode=1 (NOP), W_stat=AOK, both dst fields=RNONE, both val fields=0.
REQ-023: When stall and bubble are both asserted, stall SHALL win and all W registers SHALL hold.
REQ-024: The FSM SHALL have two states, RUN and HALTED; reset enters RUN.
REQ-025: RUN->HALTED SHALL occur on the edge that loads a W_stat other than AOK; HALTED is left only by reset.
REQ-026: In HALTED, all W registers SHALL hold regardless of stall or bubble, and halted=1.
REQ-027: rf_we_E SHALL be 1 iff W_stat=AOK and W_dstE!=RNONE; rf_we_M likewise with W_dstM. Both are combinational from W registers.
REQ-028: A faulting (ADR/INS) or HLT instruction SHALL never assert rf_we_E or rf_we_M.

Reset
REQ-029: Reset SHALL set: W_icode=1, W_stat=AOK, W_dstE=W_dstM=RNONE, W_valE=W_valM=0, state RUN, halted=0, retired_count=0.
REQ-030: Reset asserted mid-stall or in HALTED SHALL take effect on the same edge, overriding all other controls.

Configuration
REQ-031: With MEMWB_PERF_CNT_EN defined, retired_count SHALL increment by 1 on each load edge whose loaded W_stat is AOK; bubbles, stalls and HALTED do not count.
REQ-032: retired_count SHALL saturate at 2^64-1.
REQ-033: Without MEMWB_PERF_CNT_EN, the retired_count port and the counter logic SHALL be absent.

Verification
REQ-034: Load m_mem_read=1, readdata=64'hDEAD_BEEF, m_dstM=3, m_stat=1 -> next cycle: W_valM=64'hDEAD_BEEF, rf_we_M=1, rf_we_E=0.
REQ-035: stall=1 and bubble=1 with new inputs -> W unchanged; then bubble=1 alone -> W_icode=1, dsts=4'hF, rf_we_*=0.
REQ-036: Load with m_dmem_error=1, m_stat=1, m_dstM=5 -> W_stat=3, rf_we_M=0, halted=1; later inputs ignored until reset.
REQ-037: Load with m_stat=2 (HLT) -> halted=1 next cycle; reset pulse -> W_icode=1, W_stat=1, halted=0.
REQ-038: With MEMWB_PERF_CNT_EN defined: 5 AOK loads, 2 bubbles and 3 stall cycles -> retired_count=5; counter preset to all-ones plus one more AOK load -> stays all-ones.
